// File: rtl/retire_trace_tx.sv
// retire_trace_tx: captures retiring WB-stage instructions into a small FIFO
// and streams them to a trace sink over valid/ready. It flags the halting
// syscall and raises done once that record has left the FIFO.
// Optional feature macro: RETIRE_TRACE_SEQ_EN adds a per-record sequence
// number output (trace_seq).
module retire_trace_tx #(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              retire_in,
    input  logic              wb_hold,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       instr_in,
    input  logic [4:0]        dest_in,
    input  logic              reg_write_in,
    input  logic [31:0]       wb_data_in,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [31:0]       trace_pc,
    output logic [31:0]       trace_instr,
    output logic [31:0]       trace_data,
    output logic [4:0]        trace_dest,
    output logic              trace_we,
    output logic              trace_last,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count,
    output logic              done
`ifdef RETIRE_TRACE_SEQ_EN
    ,
    output logic [15:0]       trace_seq
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  dest;
        logic        we;
        logic [31:0] data;
        logic        last;
`ifdef RETIRE_TRACE_SEQ_EN
        logic [15:0] seq;
`endif
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          new_rec;
    rec_t          head;
    logic [PW-1:0] wr_ptr, rd_ptr, wr_next, rd_next;
    logic          halt_seen, halt_next;
    logic          capture, is_last, rec_we;
    logic          full, empty, push, pop, drop;
`ifdef RETIRE_TRACE_SEQ_EN
    logic [15:0]   seq_cnt;
`endif

    assign is_last = (instr_in == 32'h0000_000C);
    assign capture = retire_in & ~wb_hold & (instr_in != 32'h0) & ~halt_seen;
    assign rec_we  = reg_write_in & (dest_in != 5'd0);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = ~empty & trace_ready;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign push  = capture & (~full | pop);
    assign drop  = capture & ~push;

    assign wr_next   = wr_ptr + PW'(push);
    assign rd_next   = rd_ptr + PW'(pop);
    assign halt_next = halt_seen | (capture & is_last);

    // Assemble the record; data is zeroed when no register is written.
    always_comb begin
        new_rec       = '0;
        new_rec.pc    = pc_in;
        new_rec.instr = instr_in;
        new_rec.dest  = dest_in;
        new_rec.we    = rec_we;
        new_rec.data  = rec_we ? wb_data_in : 32'h0;
        new_rec.last  = is_last;
`ifdef RETIRE_TRACE_SEQ_EN
        new_rec.seq   = seq_cnt;
`endif
    end

    // Storage array; contents are only observed through the empty gate below.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= new_rec;
    end

    // Control state: pointers, halt tracking, drop statistics, done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            halt_seen  <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
            done       <= 1'b0;
        end else begin
            wr_ptr    <= wr_next;
            rd_ptr    <= rd_next;
            halt_seen <= halt_next;
            // Look at next-state so done rises the cycle after the final pop.
            done      <= halt_next & (wr_next == rd_next);
            if (drop) begin
                overflow <= 1'b1;
                if (~&drop_count) drop_count <= drop_count + DROP_W'(1);
            end
        end
    end

`ifdef RETIRE_TRACE_SEQ_EN
    // Sequence number advances on every capture, dropped ones included.
    always_ff @(posedge clk) begin
        if (reset)        seq_cnt <= '0;
        else if (capture) seq_cnt <= seq_cnt + 16'd1;
    end
    assign trace_seq = head.seq;
`endif

    // Head record, forced to zero while nothing is buffered.
    always_comb begin
        head = '0;
        if (!empty) head = mem[rd_ptr[AW-1:0]];
    end

    assign trace_valid = ~empty;
    assign trace_pc    = head.pc;
    assign trace_instr = head.instr;
    assign trace_dest  = head.dest;
    assign trace_we    = head.we;
    assign trace_data  = head.data;
    assign trace_last  = head.last;

endmodule

// File: tb/tb_retire_trace_tx.sv
// Directed bench for retire_trace_tx: reset, single retire, stall/NOP filter,
// backpressure overflow, full push/pop, halt/done and mid-stream reset.
module tb_retire_trace_tx;
    logic        clk_tb = 1'b0;
    logic        reset, retire_in, wb_hold, reg_write_in, trace_ready;
    logic [31:0] pc_in, instr_in, wb_data_in;
    logic [4:0]  dest_in;
    logic        trace_valid, trace_we, trace_last, overflow, done;
    logic [31:0] trace_pc, trace_instr, trace_data;
    logic [4:0]  trace_dest;
    logic [15:0] drop_count;
`ifdef RETIRE_TRACE_SEQ_EN
    logic [15:0] trace_seq;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk_tb = ~clk_tb;

    retire_trace_tx #(.DEPTH(8), .DROP_W(16)) dut (
        .clk(clk_tb), .reset(reset), .retire_in(retire_in), .wb_hold(wb_hold),
        .pc_in(pc_in), .instr_in(instr_in), .dest_in(dest_in),
        .reg_write_in(reg_write_in), .wb_data_in(wb_data_in),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_data(trace_data),
        .trace_dest(trace_dest), .trace_we(trace_we), .trace_last(trace_last),
        .overflow(overflow), .drop_count(drop_count), .done(done)
`ifdef RETIRE_TRACE_SEQ_EN
        , .trace_seq(trace_seq)
`endif
    );

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [4:0] dest, input logic rw, input logic [31:0] data);
        retire_in = 1'b1; wb_hold = 1'b0; pc_in = pc; instr_in = instr;
        dest_in = dest; reg_write_in = rw; wb_data_in = data;
    endtask

    task automatic idle();
        retire_in = 1'b0; wb_hold = 1'b0; pc_in = '0; instr_in = '0;
        dest_in = '0; reg_write_in = 1'b0; wb_data_in = '0;
    endtask

    task automatic test_reset();
        idle(); trace_ready = 1'b0; reset = 1'b1;
        @(negedge clk_tb); @(negedge clk_tb);
        reset = 1'b0;
        @(negedge clk_tb);
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", trace_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (trace_pc !== 32'h0 || trace_data !== 32'h0) begin errors++; $display("FAIL reset_data pc=%h data=%h exp=0", trace_pc, trace_data); end
    endtask

    task automatic test_single();
        trace_ready = 1'b1;
        drive(32'h0, 32'h2002_0005, 5'd2, 1'b1, 32'd5);
        @(negedge clk_tb);
        idle();
        checks++; if (trace_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", trace_valid); end
        checks++; if (trace_pc !== 32'h0 || trace_instr !== 32'h2002_0005) begin errors++; $display("FAIL single_pc_instr got=%h/%h exp=0/20020005", trace_pc, trace_instr); end
        checks++; if (trace_dest !== 5'd2 || trace_we !== 1'b1 || trace_data !== 32'd5 || trace_last !== 1'b0) begin
            errors++; $display("FAIL single_fields dest=%0d we=%0b data=%0d last=%0b exp=2/1/5/0", trace_dest, trace_we, trace_data, trace_last); end
        // Write to r0 must be reported as no write with zero data.
        drive(32'h4, 32'h2000_1234, 5'd0, 1'b1, 32'h1234);
        @(negedge clk_tb);
        idle();
        checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h4) begin errors++; $display("FAIL r0_head valid=%0b pc=%h exp=1/4", trace_valid, trace_pc); end
        checks++; if (trace_we !== 1'b0 || trace_data !== 32'h0) begin errors++; $display("FAIL r0_gate we=%0b data=%h exp=0/0", trace_we, trace_data); end
        @(negedge clk_tb);
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL single_drained got=%0b exp=0", trace_valid); end
    endtask

    task automatic test_stall_nop();
        int n;
        trace_ready = 1'b0;
        drive(32'h10, 32'h2003_000A, 5'd3, 1'b1, 32'd10);
        @(negedge clk_tb);
        wb_hold = 1'b1;
        @(negedge clk_tb);
        @(negedge clk_tb);
        drive(32'h14, 32'h0, 5'd0, 1'b0, 32'd0);
        @(negedge clk_tb);
        idle();
        @(negedge clk_tb);
        checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h10) begin errors++; $display("FAIL stall_head valid=%0b pc=%h exp=1/10", trace_valid, trace_pc); end
        trace_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (trace_valid) n++;
            @(negedge clk_tb);
        end
        checks++; if (n !== 1) begin errors++; $display("FAIL stall_count got=%0d exp=1", n); end
    endtask

    task automatic test_overflow_pushpop();
        logic [31:0] exp_pc [8];
        trace_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(32'h100 + 32'(4 * i), 32'h2400_0000 + 32'(i + 1), 5'd4, 1'b1, 32'(i));
            @(negedge clk_tb);
            if (i == 7) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%0b exp=0", overflow); end
            end
        end
        idle();
        checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h100) begin errors++; $display("FAIL ovf_head valid=%0b pc=%h exp=1/100", trace_valid, trace_pc); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL ovf_drop got=%0d exp=2", drop_count); end
        // Full FIFO: retire and pop together must not drop.
        trace_ready = 1'b1;
        drive(32'h200, 32'h2400_0099, 5'd5, 1'b1, 32'h99);
        @(negedge clk_tb);
        idle();
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL pushpop_drop got=%0d exp=2", drop_count); end
        for (int i = 0; i < 7; i++) exp_pc[i] = 32'h104 + 32'(4 * i);
        exp_pc[7] = 32'h200;
        for (int i = 0; i < 8; i++) begin
            checks++; if (trace_valid !== 1'b1 || trace_pc !== exp_pc[i]) begin
                errors++; $display("FAIL drain_%0d valid=%0b pc=%h exp=1/%h", i, trace_valid, trace_pc, exp_pc[i]); end
            @(negedge clk_tb);
        end
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0b exp=0", trace_valid); end
    endtask

    task automatic test_halt();
        trace_ready = 1'b0;
        drive(32'h300, 32'h2001_0001, 5'd1, 1'b1, 32'd1);
        @(negedge clk_tb);
        drive(32'h304, 32'h0000_000C, 5'd0, 1'b0, 32'd0);
        @(negedge clk_tb);
        drive(32'h308, 32'h2001_0002, 5'd1, 1'b1, 32'd2);
        @(negedge clk_tb);
        drive(32'h30C, 32'h2001_0003, 5'd1, 1'b1, 32'd3);
        @(negedge clk_tb);
        idle();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL halt_done_early got=%0b exp=0", done); end
        trace_ready = 1'b1;
        checks++; if (trace_pc !== 32'h300 || trace_last !== 1'b0) begin errors++; $display("FAIL halt_first pc=%h last=%0b exp=300/0", trace_pc, trace_last); end
        @(negedge clk_tb);
        checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h304 || trace_last !== 1'b1) begin
            errors++; $display("FAIL halt_rec valid=%0b pc=%h last=%0b exp=1/304/1", trace_valid, trace_pc, trace_last); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL halt_done_pre got=%0b exp=0", done); end
        @(negedge clk_tb);
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL halt_ignored valid=%0b pc=%h exp=0", trace_valid, trace_pc); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL halt_done got=%0b exp=1", done); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        @(negedge clk_tb);
        reset = 1'b0;
        trace_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(32'h400 + 32'(4 * i), 32'h2402_0000 + 32'(i + 1), 5'd2, 1'b1, 32'(i));
            @(negedge clk_tb);
        end
        idle();
        checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h400) begin errors++; $display("FAIL mid_buffered valid=%0b pc=%h exp=1/400", trace_valid, trace_pc); end
        // Leave halt state set so the reset has something to clear.
        drive(32'h500, 32'h0000_000C, 5'd0, 1'b0, 32'd0);
        @(negedge clk_tb);
        idle();
        reset = 1'b1;
        @(negedge clk_tb);
        reset = 1'b0;
        checks++; if (trace_valid !== 1'b0 || drop_count !== 16'd0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_reset valid=%0b drop=%0d done=%0b exp=0/0/0", trace_valid, drop_count, done); end
        trace_ready = 1'b1;
        drive(32'h600, 32'h2005_0007, 5'd5, 1'b1, 32'd7);
        @(negedge clk_tb);
        idle();
        checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h600 || trace_data !== 32'd7) begin
            errors++; $display("FAIL mid_after valid=%0b pc=%h data=%0d exp=1/600/7", trace_valid, trace_pc, trace_data); end
    endtask

    initial begin
        idle(); reset = 1'b1; trace_ready = 1'b0;
        test_reset();
        test_single();
        test_stall_nop();
        test_overflow_pushpop();
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/retire_trace_tx.md
# retire_trace_tx

Retirement trace transmitter: captures each instruction retiring from the WB stage of the MIPS pipeline, buffers the records in a small FIFO and sends them to a trace sink over a valid/ready handshake. It sits beside the WB stage inside `Top` and is the producer side of the commit-compare flow: the sink (bench or on-chip logger) consumes one record per retired instruction and compares it against the reference model. It also flags the end-of-program `syscall` (0x0000000C) so the sink knows when the stream is complete.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2
- `DROP_W`, 16, width of the dropped-record counter
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high; one clock; reset is synchronous and active-high
- `retire_in` in 1: WB stage holds a valid retiring instruction this cycle
- `wb_hold` in 1: WB contents are the same instruction as last cycle (stall repeat)
- `pc_in` in 32: PC of the WB instruction
- `instr_in` in 32: instruction word in WB
- `dest_in` in 5: destination register index (rd for R-type, rt for I-type)
- `reg_write_in` in 1: WB writes the register file
- `wb_data_in` in 32: value written back
- `trace_valid` out 1: record available at FIFO head
- `trace_ready` in 1: sink accepts the head record
- `trace_pc`, `trace_instr`, `trace_data` out 32 each: head record fields
- `trace_dest` out 5; `trace_we` out 1: head record fields
- `trace_last` out 1: head record is the halting syscall
- `overflow` out 1: sticky, a record was dropped
- `drop_count` out DROP_W: saturating count of dropped records
- `done` out 1: halt record has been sent and FIFO is empty

## Operation
- Capture condition: `retire_in & ~wb_hold & (instr_in != 0) & ~halt_seen`. NOP (all-zero) words and stall repeats are never recorded.
- Record fields: pc, instr, dest, `we = reg_write_in & (dest_in != 0)`, data (forced to 0 when `we` = 0), and `last = (instr_in == 32'h0000000C)`.
- When a captured record has `last` = 1, `halt_seen` is set. All further captures are ignored until reset.
- Push: a captured record is written when the FIFO is not full, or when it is full and a pop happens in the same cycle. Otherwise the record is dropped: `overflow` is set (sticky) and `drop_count` increments, saturating at all-ones.
- A dropped `last` record still sets `halt_seen`. `done` then follows on the FIFO draining.
- Pop: on `trace_valid & trace_ready`. Head fields must stay stable while `trace_valid` = 1 and `trace_ready` = 0.
- Pointers are log2(DEPTH)+1 bits. Full and empty are decided by comparing the MSB and index bits. Pointers wrap naturally.
- `done` = `halt_seen` & FIFO empty, registered.
- Reset values: `trace_valid` 0, `overflow` 0, `drop_count` 0, `done` 0, `halt_seen` 0, pointers 0. Data outputs are don't-care while `trace_valid` = 0 but are driven to 0 after reset.
- Reset asserted mid-stream discards all buffered records with no partial output.

## Timing
- Capture in cycle N gives `trace_valid` = 1 with that record in cycle N+1 if the FIFO was empty (one-cycle latency, registered head).
- Sustained throughput is one record per cycle with `trace_ready` held high.
- Push and pop in the same cycle leave the occupancy unchanged.
- `done` rises the cycle after the pop that empties the FIFO once `halt_seen` is set, or the cycle after `halt_seen` is set if the FIFO is already empty.
- `overflow` and `drop_count` update the cycle after the drop.

## Configuration
- `RETIRE_TRACE_SEQ_EN` defined: adds output `trace_seq` [15:0], a per-record sequence number. It starts at 0 after reset and increments on every captured record, including dropped ones, so the sink can locate gaps.
- Not defined: no `trace_seq` port and no sequence counter.

## Test plan
- Single retire: pc 0x0, instr 0x20020005, dest 2, we 1, data 5, sink ready → one record next cycle with exactly these fields and `trace_last` 0.
- Stall and NOP filter: same instr held 3 cycles with `wb_hold` 1 on cycles 2–3, plus an instr 0x0 retire → exactly one record emitted.
- Backpressure overflow: DEPTH 8, `trace_ready` 0, 10 consecutive retires → `trace_valid` stays 1 with the head unchanged, 8 buffered, `overflow` 1, `drop_count` 2. Releasing ready delivers the 8 records in order.
- Full with simultaneous push/pop: FIFO full, ready 1 and a retire in the same cycle → no drop, occupancy stays 8.
- Halt: retire 0x0000000C followed by 2 more retires → last record has `trace_last` 1, later retires are ignored, and `done` rises the cycle after that record pops.
- Reset mid-stream: 5 buffered records, assert `reset` one cycle → `trace_valid` 0, `drop_count` 0, `done` 0. A new retire then appears normally one cycle later.
